struct_stream_deser: RTL and testbench

//  Upstream stage for the packed-record consumer. Assembles a record from a

---
 rtl/struct_stream_deser_if.sv | 24 ++
 rtl/struct_stream_deser.sv | 64 ++++++
 tb/tb_struct_stream_deser.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/struct_stream_deser_if.sv
// struct_stream_deser_if: beat-stream input and whole-record output bundle
interface struct_stream_deser_if #(
  parameter int BEAT_W = 8,
  parameter int REC_W  = 221
);
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [REC_W-1:0]  out_rec;
  logic              out_t;
  logic [3:0]        out_x;
  logic              err;
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_rec, out_t, out_x, err
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_rec, out_t, out_x, err
  );
endinterface

// File: rtl/struct_stream_deser.sv
// struct_stream_deser: assembles a packed record from narrow beats, drops badly framed frames
module struct_stream_deser #(
  parameter int BEAT_W = 8,
  parameter int REC_W  = 221
) (
  input logic                  clk,
  input logic                  rst,
  struct_stream_deser_if.slave s
);
  localparam int BEATS = (REC_W + BEAT_W - 1) / BEAT_W;
  localparam int BUF_W = BEATS * BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [BUF_W-1:0] ONES = BUF_W'({BEAT_W{1'b1}});
  typedef enum logic [1:0] {FILL, HOLD, DRAIN} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REC_W-1:0] rec_q, rec_d;
  logic             err_q, err_d;
  logic             acc, fin;
  logic [BUF_W-1:0] beat_w;
  assign s.in_ready  = state_q != HOLD;
  assign s.out_valid = state_q == HOLD;
  assign s.out_rec   = rec_q;
  assign s.out_t     = rec_q[REC_W-1];
  assign s.out_x     = rec_q[REC_W-2 -: 4];
  assign s.err       = err_q;
  assign acc         = s.in_valid && s.in_ready;
  assign fin         = cnt_q == CNT_W'(BEATS - 1);
  assign beat_w      = BUF_W'(s.in_data);
  // Splice the accepted beat into its slot; pad bits past the record fall off the top
  always_comb
    rec_d = (acc && state_q == FILL)
          ? (rec_q & ~REC_W'(ONES << (cnt_q * BEAT_W))) | REC_W'(beat_w << (cnt_q * BEAT_W))
          : rec_q;
  // Framing FSM: count beats, flag early/missing in_last, hold record until consumed
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      FILL: if (acc) begin
        cnt_d   = (fin || s.in_last) ? '0 : cnt_q + 1'b1;
        err_d   = fin != s.in_last;
        state_d = fin ? (s.in_last ? HOLD : DRAIN) : FILL;
      end
      HOLD:    state_d = s.out_ready ? FILL : HOLD;
      DRAIN:   state_d = (acc && s.in_last) ? FILL : DRAIN;
      default: state_d = FILL;
    endcase
  end
  // State, counter, record buffer and error pulse registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      rec_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rec_q   <= rec_d;
      err_q   <= err_d;
    end
endmodule

// File: tb/tb_struct_stream_deser.sv
// tb_struct_stream_deser: directed and randomized scoreboard bench for struct_stream_deser
module tb_struct_stream_deser;
  localparam int BW = 8;
  localparam int RW = 221;
  localparam int NB = 28;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  struct_stream_deser_if #(.BEAT_W(BW), .REC_W(RW)) b();
  struct_stream_deser #(.BEAT_W(BW), .REC_W(RW)) dut (.clk(clk), .rst(rst), .s(b));
  logic [RW-1:0] q[$];
  int   n_chk = 0, n_fail = 0, n_err = 0, n_rec = 0;
  bit   rnd_mode = 1'b0;
  logic man_rdy = 1'b0, rnd_rdy = 1'b0;
  assign b.out_ready = rnd_mode ? rnd_rdy : man_rdy;
  always @(posedge clk) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end
  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (b.err === 1'b1) n_err++;
    if (!rst && b.out_valid && b.out_ready) begin
      logic [RW-1:0] e;
      n_rec++;
      chk("rec_queued", RW'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_rec", b.out_rec, e);
        chk("out_t", b.out_t, e[RW-1]);
        chk("out_x", b.out_x, e[RW-2 -: 4]);
      end
    end
  end
  task automatic sync;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [BW-1:0] d, input logic l, input int gap);
    bit acc = 1'b0;
    int t = 0;
    while (!acc && t < 1000) begin
      b.in_valid = ($urandom_range(0, 99) >= gap);
      b.in_data  = b.in_valid ? d : BW'($urandom);
      b.in_last  = b.in_valid ? l : 1'($urandom);
      @(negedge clk);
      acc = b.in_valid && b.in_ready;
      sync;
      t++;
    end
    b.in_valid = 1'b0;
    b.in_last  = 1'b0;
    chk("beat_accepted", RW'(acc), 1);
  endtask
  task automatic frame(input int n, input int last_idx, input int gap, input bit push, input bit seq);
    logic [BW-1:0]    d[$];
    logic [NB*BW-1:0] f = '0;
    for (int k = 0; k < n; k++) begin
      d.push_back(seq ? BW'(k) : BW'($urandom));
      if (k < NB) f = f | ((NB*BW)'(d[k]) << (k * BW));
    end
    if (push) q.push_back(f[RW-1:0]);
    for (int k = 0; k < n; k++) beat(d[k], k == last_idx, gap);
  endtask
  task automatic drain(input string tag);
    int t = 0;
    while (q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(tag, RW'(q.size()), 0);
  endtask
  task automatic pulse_rst;
    rst = 1'b1;
    sync;
    rst = 1'b0;
  endtask
  initial begin
    int e0, r0;
    b.in_valid = 1'b0;
    b.in_data  = '0;
    b.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_out_rec", b.out_rec, 0);
    chk("rst_err", b.err, 0);
    chk("rst_in_ready", b.in_ready, 1);
    sync;
    frame(NB, NB - 1, 0, 1, 1);
    @(negedge clk);
    chk("t1_out_valid", b.out_valid, 1);
    chk("t1_rec", b.out_rec, q[0]);
    chk("t1_rec_lo", b.out_rec[7:0], 8'h00);
    chk("t1_rec_beat26", b.out_rec[215:208], 8'h1A);
    chk("t1_out_t", b.out_t, 1'b1);
    chk("t1_out_x", b.out_x, 4'hB);
    chk("t1_err", b.err, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", b.out_valid, 1);
      chk("t2_hold_in_ready", b.in_ready, 0);
      chk("t2_hold_rec", b.out_rec, q[0]);
      @(negedge clk);
    end
    sync;
    man_rdy = 1'b1;
    sync;
    @(negedge clk);
    chk("t2_out_valid_drop", b.out_valid, 0);
    chk("t2_in_ready_back", b.in_ready, 1);
    chk("t2_records", RW'(n_rec), 1);
    sync;
    e0 = n_err;
    frame(6, 5, 0, 0, 0);
    @(negedge clk);
    chk("t3_err_pulse", b.err, 1);
    chk("t3_no_valid", b.out_valid, 0);
    @(negedge clk);
    chk("t3_err_width", b.err, 0);
    sync;
    frame(NB, NB - 1, 0, 1, 0);
    drain("t3_drain");
    chk("t3_err_count", RW'(n_err - e0), 1);
    e0 = n_err;
    frame(NB, -1, 0, 0, 0);
    @(negedge clk);
    chk("t4_err_pulse", b.err, 1);
    chk("t4_drain_ready", b.in_ready, 1);
    chk("t4_no_valid", b.out_valid, 0);
    sync;
    frame(3, 2, 0, 0, 0);
    @(negedge clk);
    chk("t4_drained_no_valid", b.out_valid, 0);
    chk("t4_drained_no_err", b.err, 0);
    sync;
    frame(NB, NB - 1, 0, 1, 0);
    drain("t4_drain");
    chk("t4_err_count", RW'(n_err - e0), 1);
    e0 = n_err;
    r0 = n_rec;
    rnd_mode = 1'b1;
    for (int i = 0; i < 200; i++) frame(NB, NB - 1, 50, 1, 0);
    drain("t5_drain");
    chk("t5_err_count", RW'(n_err - e0), 0);
    chk("t5_records", RW'(n_rec - r0), 200);
    rnd_mode = 1'b0;
    man_rdy  = 1'b0;
    sync;
    e0 = n_err;
    frame(14, -1, 0, 0, 0);
    pulse_rst;
    @(negedge clk);
    chk("t6a_out_valid", b.out_valid, 0);
    chk("t6a_err", b.err, 0);
    chk("t6a_in_ready", b.in_ready, 1);
    sync;
    frame(NB, NB - 1, 0, 1, 0);
    @(negedge clk);
    chk("t6_hold_valid", b.out_valid, 1);
    sync;
    pulse_rst;
    void'(q.pop_front());
    @(negedge clk);
    chk("t6b_out_valid", b.out_valid, 0);
    chk("t6b_err", b.err, 0);
    chk("t6b_in_ready", b.in_ready, 1);
    chk("t6b_out_rec", b.out_rec, 0);
    sync;
    man_rdy = 1'b1;
    frame(NB, NB - 1, 0, 1, 0);
    drain("t6_drain");
    chk("t6_err_count", RW'(n_err - e0), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
